compare_serial: RTL and testbench

- Sequential multi-digit magnitude comparator built around the existing compare2 2-bit comparator.
- Accepts two WIDTH-bit unsigned operands on a start pulse.
- Shifts them MSB-first, 2 bits per cycle, into compare2 and folds each digit's GT/EQ/LT into a final registered result.
- Sits directly upstream of compare2 as its driver, and downstream of it as its consumer. This is the team's path from the 2-bit comparator to arbitrary-width compares.

---
 rtl/cmp_pkg.sv | 12 +
 rtl/compare2.sv | 16 +
 rtl/compare_serial.sv | 120 ++++++++++++
 tb/tb_compare_serial.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared constants for the serial magnitude comparator and its 2-bit digit comparator.
package cmp_pkg;

   localparam int unsigned DIGIT_W = 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/compare2.sv
// 2-bit unsigned magnitude comparator; exactly one of gt/eq/lt is high.
module compare2
   import cmp_pkg::*;
(
   output logic               gt,
   output logic               eq,
   output logic               lt,
   input  logic [DIGIT_W-1:0] x,
   input  logic [DIGIT_W-1:0] y
);

   assign gt = (x > y);
   assign eq = (x == y);
   assign lt = (x < y);

endmodule

// File: rtl/compare_serial.sv
// Multi-digit unsigned comparator: scans operands MSB-first, one 2-bit digit per
// cycle through compare2, and folds the digit results into a held gt/eq/lt.
module compare_serial
   import cmp_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter bit          EARLY_EXIT = 1'b1
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             eq,
   output logic             lt
);

   localparam int unsigned DIGITS = WIDTH / DIGIT_W;
   localparam int unsigned CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_sh_q, a_sh_d;
   logic [WIDTH-1:0]   b_sh_q, b_sh_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               decided_q, decided_d;
   logic               gt_d, eq_d, lt_d;
   logic               dig_gt, dig_eq, dig_lt;

   // Top digit of each shift register is the digit under test this cycle
   compare2 u_compare2 (
      .gt (dig_gt),
      .eq (dig_eq),
      .lt (dig_lt),
      .x  (a_sh_q[WIDTH-1 -: DIGIT_W]),
      .y  (b_sh_q[WIDTH-1 -: DIGIT_W])
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         a_sh_q    <= '0;
         b_sh_q    <= '0;
         cnt_q     <= '0;
         decided_q <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         gt        <= 1'b0;
         eq        <= 1'b0;
         lt        <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_sh_q    <= a_sh_d;
         b_sh_q    <= b_sh_d;
         cnt_q     <= cnt_d;
         decided_q <= decided_d;
         busy      <= (state_d == S_RUN);
         done      <= (state_d == S_DONE);
         gt        <= gt_d;
         eq        <= eq_d;
         lt        <= lt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      a_sh_d    = a_sh_q;
      b_sh_d    = b_sh_q;
      cnt_d     = cnt_q;
      decided_d = decided_q;
      gt_d      = gt;
      eq_d      = eq;
      lt_d      = lt;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_sh_d    = a;
               b_sh_d    = b;
               cnt_d     = CNT_W'(DIGITS - 1);
               decided_d = 1'b0;
               gt_d      = 1'b0;
               eq_d      = 1'b0;
               lt_d      = 1'b0;
               state_d   = S_RUN;
            end
         end
         S_RUN: begin
            a_sh_d = a_sh_q << DIGIT_W;
            b_sh_d = b_sh_q << DIGIT_W;
            cnt_d  = cnt_q - CNT_W'(1);
            // The first differing digit decides; later digits are ignored
            if (!decided_q && !dig_eq) begin
               gt_d      = dig_gt;
               lt_d      = dig_lt;
               decided_d = 1'b1;
               if (EARLY_EXIT) begin
                  state_d = S_DONE;
               end
            end
            if (cnt_q == '0) begin
               state_d = S_DONE;
               if (!decided_q && dig_eq) begin
                  eq_d = 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_compare_serial.sv
// Directed bench for compare_serial: early-exit and full-scan 8-bit instances
// plus a 2-bit instance, all driven from the same start/operand stimulus.
module tb_compare_serial;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a, b;
   logic [1:0] a2, b2;

   logic busy1, done1, gt1, eq1, lt1;
   logic busy0, done0, gt0, eq0, lt0;
   logic busy2, done2, gt2, eq2, lt2;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   assign a2 = a[1:0];
   assign b2 = b[1:0];

   compare_serial #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_ee1 (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy1), .done(done1), .gt(gt1), .eq(eq1), .lt(lt1));

   compare_serial #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_ee0 (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy0), .done(done0), .gt(gt0), .eq(eq0), .lt(lt0));

   compare_serial #(.WIDTH(2), .EARLY_EXIT(1'b1)) u_w2 (
      .clk(clk), .rst(rst), .start(start), .a(a2), .b(b2),
      .busy(busy2), .done(done2), .gt(gt2), .eq(eq2), .lt(lt2));

   localparam logic [2:0] R_GT = 3'b100;
   localparam logic [2:0] R_EQ = 3'b010;
   localparam logic [2:0] R_LT = 3'b001;

   typedef struct {
      logic [7:0] va;
      logic [7:0] vb;
      logic [2:0] res;
      int         done_ee1;
      int         done_ee0;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference for the 2-bit instance
   function automatic logic [2:0] ref2(input logic [1:0] x, input logic [1:0] y);
      if (x > y)       return R_GT;
      else if (x == y) return R_EQ;
      else             return R_LT;
   endfunction

   task automatic run_op(input string name, input logic [7:0] ta, input logic [7:0] tb_,
                         input logic [2:0] res, input int d1, input int d0, input int ign);
      int         dc1, dc0, dc2, nd1, nd0, nd2, bb1, bb0, bb2;
      logic [2:0] r1, r0, r2, res2;
      dc1 = 0; dc0 = 0; dc2 = 0; nd1 = 0; nd0 = 0; nd2 = 0; bb1 = 0; bb0 = 0; bb2 = 0;
      r1 = '0; r0 = '0; r2 = '0;
      res2 = ref2(ta[1:0], tb_[1:0]);
      @(negedge clk);
      start = 1'b1; a = ta; b = tb_;
      @(posedge clk);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) begin
            start = 1'b0;
            a = 8'($urandom);
            b = 8'($urandom);
         end
         if (ign != 0 && c == ign) begin
            start = 1'b1; a = 8'hFF; b = 8'h00;
         end else if (ign != 0 && c == ign + 1) begin
            start = 1'b0;
         end
         if (done1) begin if (dc1 == 0) dc1 = c; nd1++; r1 = {gt1, eq1, lt1}; end
         if (done0) begin if (dc0 == 0) dc0 = c; nd0++; r0 = {gt0, eq0, lt0}; end
         if (done2) begin if (dc2 == 0) dc2 = c; nd2++; r2 = {gt2, eq2, lt2}; end
         if (busy1 !== (c < d1)) bb1++;
         if (busy0 !== (c < d0)) bb0++;
         if (busy2 !== (c < 2))  bb2++;
      end
      chk({name, " ee1 done cycle"}, dc1, d1);
      chk({name, " ee1 done count"}, nd1, 1);
      chk({name, " ee1 busy window"}, bb1, 0);
      chk({name, " ee1 result"}, r1, res);
      chk({name, " ee1 result held"}, {gt1, eq1, lt1}, res);
      chk({name, " ee0 done cycle"}, dc0, d0);
      chk({name, " ee0 done count"}, nd0, 1);
      chk({name, " ee0 busy window"}, bb0, 0);
      chk({name, " ee0 result"}, r0, res);
      chk({name, " ee0 result held"}, {gt0, eq0, lt0}, res);
      chk({name, " w2 done cycle"}, dc2, 2);
      chk({name, " w2 done count"}, nd2, 1);
      chk({name, " w2 busy window"}, bb2, 0);
      chk({name, " w2 result held"}, {gt2, eq2, lt2}, res2);
   endtask

   vec_t vecs[10];

   initial begin
      int ndone;
      vecs[0] = '{8'hA5, 8'hA5, R_EQ, 5, 5};
      vecs[1] = '{8'h80, 8'h7F, R_GT, 2, 5};
      vecs[2] = '{8'h12, 8'h13, R_LT, 5, 5};
      vecs[3] = '{8'hC0, 8'h00, R_GT, 2, 5};
      vecs[4] = '{8'h00, 8'h00, R_EQ, 5, 5};
      vecs[5] = '{8'hFF, 8'h00, R_GT, 2, 5};
      vecs[6] = '{8'h34, 8'h3C, R_LT, 4, 5};
      vecs[7] = '{8'h01, 8'h02, R_LT, 5, 5};
      vecs[8] = '{8'h4F, 8'h50, R_LT, 3, 5};
      vecs[9] = '{8'hB0, 8'h8F, R_GT, 3, 5};

      rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset ee1 outputs", {busy1, done1, gt1, eq1, lt1}, 0);
      chk("reset ee0 outputs", {busy0, done0, gt0, eq0, lt0}, 0);
      chk("reset w2 outputs",  {busy2, done2, gt2, eq2, lt2}, 0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].res,
                vecs[i].done_ee1, vecs[i].done_ee0, 0);
      end

      // Start during RUN/DONE is ignored; the following op starts normally
      run_op("ignored start", 8'h01, 8'h02, R_LT, 5, 5, 2);
      run_op("after ignored", 8'h80, 8'h7F, R_GT, 2, 5, 0);

      // Reset in RUN cycle 2 aborts without a done pulse
      @(negedge clk);
      start = 1'b1; a = 8'h12; b = 8'h13;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort ee1 outputs", {busy1, done1, gt1, eq1, lt1}, 0);
      chk("abort ee0 outputs", {busy0, done0, gt0, eq0, lt0}, 0);
      chk("abort w2 outputs",  {busy2, done2, gt2, eq2, lt2}, 0);
      rst = 1'b0;
      ndone = 0;
      repeat (8) begin
         @(negedge clk);
         if (done1) ndone++;
         if (done0) ndone++;
         if (done2) ndone++;
      end
      chk("abort no done pulse", ndone, 0);

      run_op("post-abort", 8'h00, 8'h00, R_EQ, 5, 5, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
